mem_port_arbiter: RTL

//  Shares one single-ported unified memory between the CPU's instruction fetch (IM_R/pc/inst)
//  and its data access (DM_CS/DM_R/DM_W/addr/wdata/rdata). Serialises the two requesters,

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_bus_timer.sv | 30 +++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, access owner, timeout default.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int TIMEOUT_DEFAULT = 16;

    // Counter width able to hold 0..timeout-1 (timeout >= 2).
    function automatic int timer_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_timer.sv
// Counts cycles while enabled and flags the last permitted cycle of an access.
module bus_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = timer_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // High during the TIMEOUT-th busy cycle; the FSM aborts unless mem_ready arrives then.
    assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU instruction fetch and data access onto one single-ported memory, stalling the CPU.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          cpu_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          bus_err
);

    state_t        state_reg, state_next;
    owner_t        owner_reg;
    logic          grant, grant_data;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [DW-1:0] i_rdata_reg, d_rdata_reg;
    logic          bus_err_reg;
    logic          busy, expired, is_load_or_fetch;

    assign busy = (state_reg == ST_BUSY);

    bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy),
        .expired (expired)
    );

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        grant_data = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Data first: the current instruction's access precedes the next fetch.
                if (d_req) begin
                    grant      = 1'b1;
                    grant_data = 1'b1;
                    state_next = ST_BUSY;
                end else if (i_req) begin
                    grant      = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready || expired) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Stores never touch d_rdata, neither on completion nor on abort.
    assign is_load_or_fetch = (owner_reg == OWN_FETCH) || !mem_we_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWN_FETCH;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_reg     <= grant_data ? OWN_DATA : OWN_FETCH;
                mem_addr_reg  <= grant_data ? d_addr : i_addr;
                mem_wdata_reg <= grant_data ? d_wdata : '0;
                mem_we_reg    <= grant_data && d_we;
            end
            if (busy && (mem_ready || expired) && is_load_or_fetch) begin
                if (owner_reg == OWN_FETCH) begin
                    i_rdata_reg <= mem_ready ? mem_rdata : '0;
                end else begin
                    d_rdata_reg <= mem_ready ? mem_rdata : '0;
                end
            end
            if (busy && !mem_ready && expired) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign mem_en    = busy;
    assign mem_we    = busy && mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign i_ack     = (state_reg == ST_RESP) && (owner_reg == OWN_FETCH);
    assign d_ack     = (state_reg == ST_RESP) && (owner_reg == OWN_DATA);
    assign i_rdata   = i_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign bus_err   = bus_err_reg;
    assign cpu_stall = (i_req && !i_ack) || (d_req && !d_ack);

endmodule
